adio_adc_rx: RTL and testbench

//  Serial audio receiver for the codec ADC path. It deserialises AUD_ADCDAT into 16-bit left/right PCM pairs.
//  Bit and word timing come from the BCK/LRCK that the FPGA already drives to the codec (left-justified, MSB first).

---
 rtl/audio_pkg.sv | 19 +
 rtl/adio_adc_rx_if.sv | 13 +
 rtl/aud_sync_edge.sv | 34 +++
 rtl/adio_adc_rx.sv | 164 ++++++++++++++++
 tb/tb_adio_adc_rx.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio timing constants, receiver state encoding and PCM pair type
package audio_pkg;

    localparam int REF_CLK     = 18432000;
    localparam int SAMPLE_RATE = 48000;
    localparam int DATA_WIDTH  = 16;
    localparam int BCK_HALF    = 6;
    localparam int LRCK_HALF   = 192;

    typedef logic [0:0] rx_state_t;
    localparam rx_state_t SEEK = 1'b0;
    localparam rx_state_t RECV = 1'b1;

    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
    } pcm_pair_t;

endpackage

// File: rtl/adio_adc_rx_if.sv
// rtl/adio_adc_rx_if.sv - valid/ready stereo PCM pair interface
// Ports: left/right samples and valid from the producer, ready from the consumer.
interface adio_adc_rx_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
    logic                  valid;
    logic                  ready;

    modport master (output left, output right, output valid, input ready);
    modport slave  (input left, input right, input valid, output ready);
endinterface

// File: rtl/aud_sync_edge.sv
// rtl/aud_sync_edge.sv - multi-stage synchroniser with a delay stage and edge detection
// Ports: clk_i/rst_ni clock and async active-low reset, din_i asynchronous input,
//        level_o synchronised level, rise_o/fall_o/edge_o one-cycle edge strobes.
module aud_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~dly_q;
    assign fall_o  = ~level_o & dly_q;
    assign edge_o  = level_o ^ dly_q;

endmodule

// File: rtl/adio_adc_rx.sv
// rtl/adio_adc_rx.sv - left-justified serial ADC receiver producing 16-bit stereo PCM pairs
// Ports: iCLK_18_4 system clock, iRST_N async active-low reset,
//        iAUD_BCK/iAUD_LRCK/iAUD_ADCDAT codec serial inputs,
//        pcm_o stereo pair valid/ready output, oOverrun sticky drop flag with iClrOvr clear,
//        oFrameErr short-word pulse, oLocked high while receiving words.
module adio_adc_rx
    import audio_pkg::*;
#(
    parameter int   DATA_WIDTH  = 16,
    parameter logic LEFT_POL    = 1'b1,
    parameter int   SYNC_STAGES = 2
) (
    input  logic                 iCLK_18_4,
    input  logic                 iRST_N,
    input  logic                 iAUD_BCK,
    input  logic                 iAUD_LRCK,
    input  logic                 iAUD_ADCDAT,
    adio_adc_rx_if.master        pcm_o,
    output logic                 oOverrun,
    input  logic                 iClrOvr,
    output logic                 oFrameErr,
    output logic                 oLocked
);

    localparam int             CNT_W    = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic bck_rise, lrck_lvl, lrck_edge, data_lvl;
    logic unused_bck_lvl, unused_bck_fall, unused_bck_edge;
    logic unused_lrck_rise, unused_lrck_fall;
    logic unused_dat_rise, unused_dat_fall, unused_dat_edge;

    aud_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bck (
        .clk_i(iCLK_18_4), .rst_ni(iRST_N), .din_i(iAUD_BCK),
        .level_o(unused_bck_lvl), .rise_o(bck_rise), .fall_o(unused_bck_fall), .edge_o(unused_bck_edge)
    );

    aud_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk_i(iCLK_18_4), .rst_ni(iRST_N), .din_i(iAUD_LRCK),
        .level_o(lrck_lvl), .rise_o(unused_lrck_rise), .fall_o(unused_lrck_fall), .edge_o(lrck_edge)
    );

    aud_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
        .clk_i(iCLK_18_4), .rst_ni(iRST_N), .din_i(iAUD_ADCDAT),
        .level_o(data_lvl), .rise_o(unused_dat_rise), .fall_o(unused_dat_fall), .edge_o(unused_dat_edge)
    );

    rx_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] held_left_q, held_left_d;
    logic                  chan_left_q, chan_left_d;
    logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;
    logic                  ferr_q, ferr_d;
    logic                  pair_done;
    logic                  lrck_is_left;

    // Word framing: the LRCK edge is resolved first so a coincident BCK rise
    // lands as bit 0 of the new word.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        held_left_d  = held_left_q;
        chan_left_d  = chan_left_q;
        ferr_d       = 1'b0;
        pair_done    = 1'b0;
        lrck_is_left = (lrck_lvl == LEFT_POL);

        if (lrck_edge) begin
            if (state_q == SEEK) begin
                if (lrck_is_left) begin
                    state_d     = RECV;
                    cnt_d       = '0;
                    shift_d     = '0;
                    chan_left_d = 1'b1;
                end
            end else if (cnt_q < CNT_FULL) begin
                // Short word: drop the partial frame; a new left half resyncs immediately.
                ferr_d      = 1'b1;
                cnt_d       = '0;
                shift_d     = '0;
                chan_left_d = lrck_is_left;
                state_d     = lrck_is_left ? RECV : SEEK;
            end else begin
                cnt_d       = '0;
                chan_left_d = lrck_is_left;
            end
        end

        // Bits beyond DATA_WIDTH in a slot are ignored; the counter saturates.
        if (state_d == RECV && bck_rise && cnt_d < CNT_FULL) begin
            shift_d = {shift_d[DATA_WIDTH-2:0], data_lvl};
            cnt_d   = cnt_d + CNT_ONE;
            if (cnt_d == CNT_FULL) begin
                if (chan_left_d) begin
                    held_left_d = shift_d;
                end else begin
                    pair_done = 1'b1;
                end
            end
        end
    end

    // Output holding register: a new pair may replace an accepted one in the same cycle,
    // otherwise it is dropped and flagged while a pair is still pending.
    always_comb begin
        valid_d = valid_q;
        left_d  = left_q;
        right_d = right_q;
        ovr_d   = ovr_q;
        if (iClrOvr) begin
            ovr_d = 1'b0;
        end
        if (pair_done) begin
            if (!valid_q || pcm_o.ready) begin
                left_d  = held_left_q;
                right_d = shift_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && pcm_o.ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= SEEK;
            cnt_q       <= '0;
            shift_q     <= '0;
            held_left_q <= '0;
            chan_left_q <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            held_left_q <= held_left_d;
            chan_left_q <= chan_left_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign pcm_o.left  = left_q;
    assign pcm_o.right = right_q;
    assign pcm_o.valid = valid_q;
    assign oOverrun    = ovr_q;
    assign oFrameErr   = ferr_q;
    assign oLocked     = (state_q == RECV);

endmodule

// File: tb/tb_adio_adc_rx.sv
// tb/tb_adio_adc_rx.sv - directed self-checking bench for adio_adc_rx
module tb_adio_adc_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bck = 1'b0;
    logic lrck = 1'b0;
    logic adcdat = 1'b0;
    logic clr_ovr = 1'b0;
    logic overrun, frame_err, locked;

    int tot = 0;
    int bad = 0;

    int acc_cnt = 0;
    int fe_cnt = 0;
    int vrise_cnt = 0;
    logic valid_prev = 1'b0;
    logic [15:0] acc_l = '0;
    logic [15:0] acc_r = '0;
    int acc_ref = 0;

    adio_adc_rx_if #(.DATA_WIDTH(16)) pcm_if ();

    adio_adc_rx #(.DATA_WIDTH(16), .LEFT_POL(1'b1), .SYNC_STAGES(2)) dut (
        .iCLK_18_4(clk), .iRST_N(rst_n), .iAUD_BCK(bck), .iAUD_LRCK(lrck),
        .iAUD_ADCDAT(adcdat), .pcm_o(pcm_if), .oOverrun(overrun), .iClrOvr(clr_ovr),
        .oFrameErr(frame_err), .oLocked(locked)
    );

    always #27 clk = ~clk;

    always @(negedge clk) begin
        if (pcm_if.valid && pcm_if.ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_l   <= pcm_if.left;
            acc_r   <= pcm_if.right;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (pcm_if.valid && !valid_prev) vrise_cnt <= vrise_cnt + 1;
        valid_prev <= pcm_if.valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bck = 1'b0;
        repeat (n) tick();
    endtask

    // mode 1: latency check on the last data bit; mode 2: ready pulse on the completion cycle
    task automatic send_half(input logic lr, input logic [15:0] w, input int ndata, input int ntotal, input int mode);
        for (int i = 0; i < ntotal; i++) begin
            bck = 1'b0;
            if (i == 0) lrck = lr;
            adcdat = (i < ndata) ? w[15-i] : i[0];
            repeat (6) tick();
            bck = 1'b1;
            if (i == ndata - 1 && mode == 1) begin
                tick();
                tot++; if (pcm_if.valid !== 1'b0) begin bad++; $display("FAIL lat_clk1 got=%b want=0", pcm_if.valid); end
                tick();
                tot++; if (pcm_if.valid !== 1'b0) begin bad++; $display("FAIL lat_clk2 got=%b want=0", pcm_if.valid); end
                tick();
                tot++; if (pcm_if.valid !== 1'b1) begin bad++; $display("FAIL lat_clk3 got=%b want=1", pcm_if.valid); end
                repeat (3) tick();
            end else if (i == ndata - 1 && mode == 2) begin
                tick();
                tick();
                pcm_if.ready = 1'b1;
                tick();
                pcm_if.ready = 1'b0;
                tot++; if (pcm_if.valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", pcm_if.valid); end
                tot++; if (pcm_if.left !== 16'h0303) begin bad++; $display("FAIL b2b_left got=%h want=0303", pcm_if.left); end
                tot++; if (pcm_if.right !== 16'h0404) begin bad++; $display("FAIL b2b_right got=%h want=0404", pcm_if.right); end
                tot++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_ovr got=%b want=0", overrun); end
                tot++; if (acc_cnt !== acc_ref + 1) begin bad++; $display("FAIL b2b_acc_cnt got=%0d want=%0d", acc_cnt, acc_ref + 1); end
                tot++; if (acc_l !== 16'h0101) begin bad++; $display("FAIL b2b_old_left got=%h want=0101", acc_l); end
                repeat (3) tick();
            end else begin
                repeat (6) tick();
            end
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_half(1'b1, l, 16, 16, 0);
        send_half(1'b0, r, 16, 16, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pcm_if.ready = 1'b0;
        repeat (3) tick();
        tot++; if (pcm_if.valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", pcm_if.valid); end
        tot++; if (pcm_if.left !== 16'h0) begin bad++; $display("FAIL rst_left got=%h want=0000", pcm_if.left); end
        tot++; if (pcm_if.right !== 16'h0) begin bad++; $display("FAIL rst_right got=%h want=0000", pcm_if.right); end
        tot++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_ovr got=%b want=0", overrun); end
        tot++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b want=0", frame_err); end
        tot++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b want=0", locked); end
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_basic();
        int a0, v0;
        a0 = acc_cnt; v0 = vrise_cnt;
        pcm_if.ready = 1'b1;
        send_half(1'b1, 16'hA5C3, 16, 16, 0);
        send_half(1'b0, 16'h1234, 16, 16, 1);
        idle(4);
        tot++; if (acc_cnt !== a0 + 1) begin bad++; $display("FAIL basic_acc_cnt got=%0d want=%0d", acc_cnt, a0 + 1); end
        tot++; if (vrise_cnt !== v0 + 1) begin bad++; $display("FAIL basic_vrise got=%0d want=%0d", vrise_cnt, v0 + 1); end
        tot++; if (acc_l !== 16'hA5C3) begin bad++; $display("FAIL basic_left got=%h want=a5c3", acc_l); end
        tot++; if (acc_r !== 16'h1234) begin bad++; $display("FAIL basic_right got=%h want=1234", acc_r); end
        tot++; if (pcm_if.valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b want=0", pcm_if.valid); end
        tot++; if (locked !== 1'b1) begin bad++; $display("FAIL basic_locked got=%b want=1", locked); end
    endtask

    task automatic test_overrun();
        pcm_if.ready = 1'b0;
        send_frame(16'h0001, 16'h0002);
        send_frame(16'h0003, 16'h0004);
        idle(4);
        tot++; if (pcm_if.valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", pcm_if.valid); end
        tot++; if (pcm_if.left !== 16'h0001) begin bad++; $display("FAIL ovr_left got=%h want=0001", pcm_if.left); end
        tot++; if (pcm_if.right !== 16'h0002) begin bad++; $display("FAIL ovr_right got=%h want=0002", pcm_if.right); end
        tot++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", overrun); end
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        tot++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", overrun); end
        pcm_if.ready = 1'b1;
        tick();
        pcm_if.ready = 1'b0;
        tot++; if (pcm_if.valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b want=0", pcm_if.valid); end
        tot++; if (acc_l !== 16'h0001 || acc_r !== 16'h0002) begin bad++; $display("FAIL ovr_drain_data got=%h/%h want=0001/0002", acc_l, acc_r); end
    endtask

    task automatic test_frame_err();
        int f0, v0, a0;
        pcm_if.ready = 1'b1;
        f0 = fe_cnt; v0 = vrise_cnt;
        send_half(1'b1, 16'hFFC0, 10, 10, 0);
        send_half(1'b0, 16'h0F0F, 16, 16, 0);
        idle(4);
        tot++; if (fe_cnt !== f0 + 1) begin bad++; $display("FAIL ferr_pulse got=%0d want=%0d", fe_cnt, f0 + 1); end
        tot++; if (vrise_cnt !== v0) begin bad++; $display("FAIL ferr_novalid got=%0d want=%0d", vrise_cnt, v0); end
        tot++; if (locked !== 1'b0) begin bad++; $display("FAIL ferr_unlocked got=%b want=0", locked); end
        a0 = acc_cnt;
        send_frame(16'h7FFF, 16'h8000);
        idle(4);
        tot++; if (acc_cnt !== a0 + 1) begin bad++; $display("FAIL ferr_next_cnt got=%0d want=%0d", acc_cnt, a0 + 1); end
        tot++; if (acc_l !== 16'h7FFF || acc_r !== 16'h8000) begin bad++; $display("FAIL ferr_next_data got=%h/%h want=7fff/8000", acc_l, acc_r); end
        tot++; if (fe_cnt !== f0 + 1) begin bad++; $display("FAIL ferr_once got=%0d want=%0d", fe_cnt, f0 + 1); end
    endtask

    task automatic test_reset_mid();
        int a0, v0;
        pcm_if.ready = 1'b1;
        send_half(1'b1, 16'h1111, 16, 16, 0);
        send_half(1'b0, 16'h2222, 8, 8, 0);
        rst_n = 1'b0;
        #1;
        tot++; if (pcm_if.left !== 16'h0 || pcm_if.right !== 16'h0) begin bad++; $display("FAIL rmid_data got=%h/%h want=0000/0000", pcm_if.left, pcm_if.right); end
        tot++; if (locked !== 1'b0) begin bad++; $display("FAIL rmid_locked got=%b want=0", locked); end
        repeat (3) tick();
        rst_n = 1'b1;
        v0 = vrise_cnt;
        send_half(1'b0, 16'h2200, 8, 8, 0);
        idle(4);
        tot++; if (locked !== 1'b0) begin bad++; $display("FAIL rmid_seek got=%b want=0", locked); end
        tot++; if (vrise_cnt !== v0) begin bad++; $display("FAIL rmid_novalid got=%0d want=%0d", vrise_cnt, v0); end
        a0 = acc_cnt;
        send_frame(16'h4444, 16'h5555);
        idle(4);
        tot++; if (acc_cnt !== a0 + 1) begin bad++; $display("FAIL rmid_cnt got=%0d want=%0d", acc_cnt, a0 + 1); end
        tot++; if (acc_l !== 16'h4444 || acc_r !== 16'h5555) begin bad++; $display("FAIL rmid_data2 got=%h/%h want=4444/5555", acc_l, acc_r); end
        tot++; if (locked !== 1'b1) begin bad++; $display("FAIL rmid_relock got=%b want=1", locked); end
    endtask

    task automatic test_slot32();
        int a0, f0;
        pcm_if.ready = 1'b1;
        a0 = acc_cnt; f0 = fe_cnt;
        send_half(1'b1, 16'hBEEF, 16, 32, 0);
        send_half(1'b0, 16'h0F0F, 16, 32, 0);
        idle(4);
        tot++; if (acc_cnt !== a0 + 1) begin bad++; $display("FAIL s32_cnt got=%0d want=%0d", acc_cnt, a0 + 1); end
        tot++; if (acc_l !== 16'hBEEF) begin bad++; $display("FAIL s32_left got=%h want=beef", acc_l); end
        tot++; if (acc_r !== 16'h0F0F) begin bad++; $display("FAIL s32_right got=%h want=0f0f", acc_r); end
        tot++; if (fe_cnt !== f0) begin bad++; $display("FAIL s32_noferr got=%0d want=%0d", fe_cnt, f0); end
    endtask

    task automatic test_back_to_back();
        pcm_if.ready = 1'b0;
        send_frame(16'h0101, 16'h0202);
        idle(2);
        tot++; if (pcm_if.valid !== 1'b1 || pcm_if.left !== 16'h0101) begin bad++; $display("FAIL b2b_first got=%b/%h want=1/0101", pcm_if.valid, pcm_if.left); end
        acc_ref = acc_cnt;
        send_half(1'b1, 16'h0303, 16, 16, 0);
        send_half(1'b0, 16'h0404, 16, 16, 2);
        idle(2);
        pcm_if.ready = 1'b1;
        tick();
        pcm_if.ready = 1'b0;
        tot++; if (acc_l !== 16'h0303 || acc_r !== 16'h0404) begin bad++; $display("FAIL b2b_second got=%h/%h want=0303/0404", acc_l, acc_r); end
        tot++; if (pcm_if.valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b want=0", pcm_if.valid); end
    endtask

    initial begin
        pcm_if.ready = 1'b0;
        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_reset_mid();
        test_slot32();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
